imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Hardware counterpart to the bench-side instruction-memory preload.
- Accepts a little-endian byte stream over a valid/ready interface and pre-fills every instruction memory entry with NOP.
- Packs each group of 4 bytes into a 32-bit word and writes it to consecutive instruction memory addresses.
- Holds the OoO core in reset until the image is loaded, then releases it.

Parameters:
- DEPTH, 512, number of 32-bit instruction memory entries.
- ADDR_W, 9, address width; must equal clog2(DEPTH).
- NOP_WORD, 32'h00000013, fill value (ADDI x0,x0,0).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- load_start  in  1  one-cycle pulse; begins a load sequence.
- s_valid  in  1  byte-stream valid.
- s_data  in  8  byte-stream data; first byte of each word is bits [7:0].
- s_last  in  1  marks the final byte of the image; qualified by s_valid.
- s_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  instruction memory write enable.
- mem_addr  out  ADDR_W  instruction memory word address.
- mem_wdata  out  32  instruction memory write data.
- core_hold  out  1  1 = keep core in reset.
- load_done  out  1  level; image loaded and core released.
- word_count  out  ADDR_W+1  number of words written from the stream.
- err_overflow  out  1  sticky; the stream exceeded DEPTH words.
- err_partial  out  1  sticky; s_last arrived with a byte count not a multiple of 4.

Behaviour:
- Reset (rst==0, sampled at posedge):
  - State = IDLE.
  - s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - core_hold=1, load_done=0, word_count=0, both error flags=0, byte index=0.
- Reset mid-operation aborts immediately. Memory contents are then undefined, and core_hold stays 1.
- IDLE:
  - load_start=1 -> CLEAR.
  - Clear word_count, both errors and the byte index; set core_hold=1.
  - load_start while in any other state is ignored.
- CLEAR:
  - One write per cycle: mem_we=1, mem_wdata=NOP_WORD, mem_addr=0..DEPTH-1.
  - Exactly DEPTH cycles, then -> RECV with mem_addr=0.
  - s_ready=0 throughout.
- RECV:
  - s_ready=1; a byte is accepted when s_valid && s_ready.
  - Byte k of a word (k=0..3) is placed in word bits [8k+7:8k]; the index wraps 3->0.
  - On acceptance of the 4th byte, the next cycle drives mem_we=1, mem_addr=word_count[ADDR_W-1:0] and the packed word. word_count increments on that same edge.
  - Sustained throughput: 1 byte/cycle, and the write of word N overlaps reception of word N+1.
- Overflow: once word_count==DEPTH, further complete words are not written and err_overflow is set. Bytes are still accepted (the stream drains); word_count saturates at DEPTH.
- s_last:
  - If accepted with byte index 3, the final word is written normally, then -> DONE.
  - If accepted with byte index 0..2, missing upper bytes are zero-filled, the word is written, err_partial is set, then -> DONE.
- DONE:
  - Entered the cycle after the final write.
  - s_ready=0, mem_we=0, core_hold=0, load_done=1.
  - Remains in DONE until reset or load_start. load_start -> CLEAR, with core_hold=1 and load_done=0 on the next cycle.
- A stream with zero bytes is impossible: s_last is always carried by a byte.
- mem_we is never asserted outside CLEAR and the post-word write cycle.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output checksum (32).
  - XOR of every word written from the stream (NOP fill excluded); cleared on reset and on load_start.
  - Valid when load_done=1.
- When undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then load_start; bytes 13,00,00,00,33,85,a5,00(last) -> 512 NOP writes, then mem[0]=0x00000013, mem[1]=0x00a58533; word_count=2; load_done=1 and core_hold=0 one cycle after the last write.
- Same stream with s_valid toggled 1-0-1-0 -> identical memory contents; s_ready=1 throughout RECV; no write before the 4th byte.
- 6 bytes 01,02,03,04,05,06(last) -> mem[1]=0x00000605; err_partial=1; word_count=2.
- 513 full words -> words 0..511 written, word 512 dropped; err_overflow=1; word_count=512; DONE reached.
- rst=0 asserted during CLEAR at address 100 -> next cycle mem_we=0, state IDLE, core_hold=1, load_done=0; a subsequent load completes normally.
- With IMEM_LOADER_CHECKSUM_EN, words 0x00000013 and 0x00a58533 -> checksum=0x00a58520.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: streams a little-endian byte image into instruction memory.
// Every entry is first filled with NOP_WORD. Each group of four bytes is then
// packed and written to consecutive addresses while the core is held in reset.
// The core is released once the image is complete.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a 32-bit XOR checksum
// output covering the words written from the stream.
module imem_loader #(
  parameter int          DEPTH    = 512,
  parameter int          ADDR_W   = 9,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              load_done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_overflow,
  output logic              err_partial
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   WC_FULL   = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RECV,
    S_LAST,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [ADDR_W:0]   word_count_q;
  logic              err_overflow_q;
  logic              err_partial_q;
  logic [1:0]        idx_q;
  logic [31:0]       buf_q;
  logic [31:0]       word_asm;

  logic start_load;
  logic accept;
  logic word_end;
  logic clear_end;
  logic full;
  logic word_wr;

  // load_start only counts where a new load may begin; elsewhere it is ignored
  assign start_load = load_start && (state_q == S_IDLE || state_q == S_DONE);
  assign accept     = s_valid && (state_q == S_RECV);
  assign word_end   = accept && (idx_q == 2'd3 || s_last);
  assign clear_end  = (state_q == S_CLEAR) && (mem_addr_q == LAST_ADDR);
  assign full       = (word_count_q == WC_FULL);
  assign word_wr    = word_end && !full;

  // Packed word: bytes already buffered, the incoming byte, zeros above it
  always_comb begin
    word_asm = '0;
    for (int k = 0; k < 4; k++) begin
      if (k < int'(idx_q)) begin
        word_asm[8*k +: 8] = buf_q[8*k +: 8];
      end else if (k == int'(idx_q)) begin
        word_asm[8*k +: 8] = s_data;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (load_start) state_d = S_CLEAR;
      S_CLEAR: if (clear_end) state_d = S_RECV;
      S_RECV:  if (accept && s_last) state_d = S_LAST;
      S_LAST:  state_d = S_DONE;
      S_DONE:  if (load_start) state_d = S_CLEAR;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs: the core is held unless the image is complete
  always_comb begin
    s_ready   = 1'b0;
    core_hold = 1'b1;
    load_done = 1'b0;
    case (state_q)
      S_RECV: s_ready = 1'b1;
      S_DONE: begin
        core_hold = 1'b0;
        load_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Memory write port, byte packing, word counter and sticky errors
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      word_count_q   <= '0;
      err_overflow_q <= 1'b0;
      err_partial_q  <= 1'b0;
      idx_q          <= 2'd0;
    end else begin
      mem_we_q <= 1'b0;
      if (start_load) begin
        word_count_q   <= '0;
        err_overflow_q <= 1'b0;
        err_partial_q  <= 1'b0;
        idx_q          <= 2'd0;
        mem_we_q       <= 1'b1;
        mem_addr_q     <= '0;
        mem_wdata_q    <= NOP_WORD;
      end else if (state_q == S_CLEAR) begin
        if (clear_end) begin
          mem_addr_q <= '0;
        end else begin
          mem_we_q    <= 1'b1;
          mem_addr_q  <= mem_addr_q + 1'b1;
          mem_wdata_q <= NOP_WORD;
        end
      end else if (accept) begin
        if (word_end) begin
          idx_q <= 2'd0;
          if (!full) begin
            mem_we_q     <= 1'b1;
            mem_addr_q   <= word_count_q[ADDR_W-1:0];
            mem_wdata_q  <= word_asm;
            word_count_q <= word_count_q + 1'b1;
          end else begin
            err_overflow_q <= 1'b1;
          end
          if (s_last && idx_q != 2'd3) begin
            err_partial_q <= 1'b1;
          end
        end else begin
          buf_q[{idx_q, 3'b000} +: 8] <= s_data;
          idx_q                       <= idx_q + 2'd1;
        end
      end
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign word_count   = word_count_q;
  assign err_overflow = err_overflow_q;
  assign err_partial  = err_partial_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] checksum_q;

  // Running XOR of stream words actually written to memory
  always_ff @(posedge clk) begin
    if (!rst) begin
      checksum_q <= '0;
    end else if (start_load) begin
      checksum_q <= '0;
    end else if (word_wr) begin
      checksum_q <= checksum_q ^ word_asm;
    end
  end

  assign checksum = checksum_q;
`else
  logic unused_word_wr;
  assign unused_word_wr = word_wr;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: random and directed byte streams checked against
// an image model built from the stream itself.
module tb_imem_loader;

  localparam int          DEPTH  = 512;
  localparam int          ADDR_W = 9;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              load_start = 1'b0;
  logic              s_valid = 1'b0;
  logic [7:0]        s_data = 8'h00;
  logic              s_last = 1'b0;
  logic              s_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_hold;
  logic              load_done;
  logic [ADDR_W:0]   word_count;
  logic              err_overflow;
  logic              err_partial;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]       checksum;
`endif

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP_WORD(NOP)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_start   (load_start),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .core_hold    (core_hold),
    .load_done    (load_done),
    .word_count   (word_count),
    .err_overflow (err_overflow),
    .err_partial  (err_partial)
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    .checksum     (checksum)
`endif
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Memory model that records what the loader writes
  logic [31:0] tbmem [DEPTH];
  logic        poison_req = 1'b0;
  logic [7:0]  stim [$];

  always @(posedge clk) begin
    if (poison_req) begin
      for (int i = 0; i < DEPTH; i++) tbmem[i] <= 32'hDEAD_BEEF;
    end else if (mem_we === 1'b1) begin
      tbmem[mem_addr] <= mem_wdata;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  // Full load of the bytes in stim; gap_mode 0 = dense, 1 = alternate, 2 = random
  task automatic run_load(input int gap_mode, input bit mid_start);
    int n;
    int nw;
    int bad;
    int wr_bad;
    int rdy_bad;
    int widx;
    bit completes;
    logic [31:0] w;
    logic [31:0] expv;
    logic [31:0] exp_w [$];
    logic [31:0] exp_sum;
    n  = stim.size();
    nw = (n + 3) / 4;
    exp_w.delete();
    exp_sum = 32'h0;
    for (int i = 0; i < nw; i++) begin
      w = 32'h0;
      for (int k = 0; k < 4; k++)
        if (4*i + k < n) w[8*k +: 8] = stim[4*i + k];
      exp_w.push_back(w);
      if (i < DEPTH) exp_sum = exp_sum ^ w;
    end

    @(posedge clk); #1;
    load_start = 1'b1; poison_req = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0; poison_req = 1'b0;

    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_we !== 1'b1 || mem_addr !== ADDR_W'(i) || mem_wdata !== NOP ||
          s_ready !== 1'b0 || core_hold !== 1'b1 || load_done !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL clear_fill: %0d bad cycles, required 0", bad);
    end
    vectors++;
    if (s_ready !== 1'b1 || mem_we !== 1'b0 || core_hold !== 1'b1) begin
      miscompares++;
      $display("FAIL recv_entry: s_ready=%b mem_we=%b core_hold=%b, required 1 0 1",
               s_ready, mem_we, core_hold);
    end

    wr_bad = 0;
    rdy_bad = 0;
    for (int j = 0; j < n; j++) begin
      int idle;
      idle = 0;
      if (gap_mode == 1 && j > 0) idle = 1;
      if (gap_mode == 2) idle = $urandom_range(0, 2);
      repeat (idle) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
        if (mem_we !== 1'b0) wr_bad++;
      end
      if (s_ready !== 1'b1) rdy_bad++;
      s_valid = 1'b1;
      s_data  = stim[j];
      s_last  = (j == n - 1);
      if (mid_start && j == n / 2) load_start = 1'b1;
      @(posedge clk); #1;
      load_start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
      completes = (j % 4 == 3) || (j == n - 1);
      widx = j / 4;
      if (completes && widx < DEPTH) begin
        if (mem_we !== 1'b1 || mem_addr !== ADDR_W'(widx) || mem_wdata !== exp_w[widx]) wr_bad++;
      end else if (mem_we !== 1'b0) begin
        wr_bad++;
      end
    end
    vectors++;
    if (rdy_bad != 0) begin
      miscompares++;
      $display("FAIL recv_ready: s_ready low on %0d bytes, required 0", rdy_bad);
    end
    vectors++;
    if (wr_bad != 0) begin
      miscompares++;
      $display("FAIL stream_writes: %0d bad write cycles, required 0", wr_bad);
    end
    vectors++;
    if (s_ready !== 1'b0 || load_done !== 1'b0 || core_hold !== 1'b1) begin
      miscompares++;
      $display("FAIL final_write_cycle: s_ready=%b load_done=%b core_hold=%b, required 0 0 1",
               s_ready, load_done, core_hold);
    end
    @(posedge clk); #1;
    vectors++;
    if (load_done !== 1'b1 || core_hold !== 1'b0 || mem_we !== 1'b0 || s_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL done_entry: load_done=%b core_hold=%b mem_we=%b s_ready=%b, required 1 0 0 0",
               load_done, core_hold, mem_we, s_ready);
    end

    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      expv = (i < nw) ? exp_w[i] : NOP;
      if (tbmem[i] !== expv) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL mem_image: %0d wrong entries, required 0", bad);
    end
    vectors++;
    if (word_count !== (ADDR_W + 1)'((nw < DEPTH) ? nw : DEPTH)) begin
      miscompares++;
      $display("FAIL word_count: got %0d, required %0d", word_count, (nw < DEPTH) ? nw : DEPTH);
    end
    vectors++;
    if (err_partial !== (n % 4 != 0) || err_overflow !== (nw > DEPTH)) begin
      miscompares++;
      $display("FAIL err_flags: partial=%b overflow=%b, required %b %b",
               err_partial, err_overflow, (n % 4 != 0), (nw > DEPTH));
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    vectors++;
    if (checksum !== exp_sum) begin
      miscompares++;
      $display("FAIL checksum: got %h, required %h", checksum, exp_sum);
    end
`endif
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (load_done !== 1'b1 || core_hold !== 1'b0 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL done_hold: load_done=%b core_hold=%b mem_we=%b, required 1 0 0",
               load_done, core_hold, mem_we);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (s_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mem_port: s_ready=%b we=%b addr=%h wdata=%h, required 0 0 0 0",
               s_ready, mem_we, mem_addr, mem_wdata);
    end
    vectors++;
    if (core_hold !== 1'b1 || load_done !== 1'b0 || word_count !== '0 ||
        err_overflow !== 1'b0 || err_partial !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_status: hold=%b done=%b wc=%0d ovf=%b part=%b, required 1 0 0 0 0",
               core_hold, load_done, word_count, err_overflow, err_partial);
    end
    rst = 1'b1;
  endtask

  task automatic load_spec_stream();
    stim.delete();
    stim.push_back(8'h13); stim.push_back(8'h00); stim.push_back(8'h00); stim.push_back(8'h00);
    stim.push_back(8'h33); stim.push_back(8'h85); stim.push_back(8'ha5); stim.push_back(8'h00);
  endtask

  task automatic test_basic();
    load_spec_stream();
    run_load(0, 1'b0);
    vectors++;
    if (tbmem[0] !== 32'h0000_0013 || tbmem[1] !== 32'h00a5_8533) begin
      miscompares++;
      $display("FAIL basic_words: mem0=%h mem1=%h, required 00000013 00a58533", tbmem[0], tbmem[1]);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    vectors++;
    if (checksum !== 32'h00a5_8520) begin
      miscompares++;
      $display("FAIL basic_checksum: got %h, required 00a58520", checksum);
    end
`endif
  endtask

  task automatic test_toggle_valid();
    load_spec_stream();
    run_load(1, 1'b0);
    vectors++;
    if (tbmem[0] !== 32'h0000_0013 || tbmem[1] !== 32'h00a5_8533) begin
      miscompares++;
      $display("FAIL toggle_words: mem0=%h mem1=%h, required 00000013 00a58533", tbmem[0], tbmem[1]);
    end
  endtask

  task automatic test_partial();
    stim.delete();
    for (int i = 1; i <= 6; i++) stim.push_back(8'(i));
    run_load(2, 1'b0);
    vectors++;
    if (tbmem[1] !== 32'h0000_0605 || err_partial !== 1'b1) begin
      miscompares++;
      $display("FAIL partial_word: mem1=%h err_partial=%b, required 00000605 1", tbmem[1], err_partial);
    end
  endtask

  task automatic test_overflow();
    stim.delete();
    for (int i = 0; i < 4 * (DEPTH + 1); i++) stim.push_back(8'($urandom));
    run_load(0, 1'b0);
    vectors++;
    if (err_overflow !== 1'b1 || word_count !== (ADDR_W + 1)'(DEPTH)) begin
      miscompares++;
      $display("FAIL overflow: err_overflow=%b word_count=%0d, required 1 %0d",
               err_overflow, word_count, DEPTH);
    end
  endtask

  task automatic test_reset_mid_clear();
    int guard;
    @(posedge clk); #1;
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    guard = 0;
    while (mem_addr !== ADDR_W'(100) && guard < 2 * DEPTH) begin
      @(posedge clk); #1;
      guard++;
    end
    vectors++;
    if (mem_addr !== ADDR_W'(100) || mem_we !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_reach_100: addr=%0d we=%b, required 100 1", mem_addr, mem_we);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (mem_we !== 1'b0 || core_hold !== 1'b1 || load_done !== 1'b0 || s_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_clear: we=%b hold=%b done=%b ready=%b, required 0 1 0 0",
               mem_we, core_hold, load_done, s_ready);
    end
    rst = 1'b1;
    guard = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (mem_we !== 1'b0 || s_ready !== 1'b0 || core_hold !== 1'b1) guard++;
    end
    vectors++;
    if (guard != 0) begin
      miscompares++;
      $display("FAIL idle_after_abort: %0d active cycles, required 0", guard);
    end
    stim.delete();
    for (int i = 0; i < 10; i++) stim.push_back(8'($urandom));
    run_load(2, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 4; it++) begin
      int n;
      n = $urandom_range(1, 40);
      if (it == 1) n = 24;
      stim.delete();
      for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
      run_load(it % 3, it == 1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle_valid();
    test_partial();
    test_overflow();
    test_reset_mid_clear();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
